sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the successor to the team's fixed 4-bit × 16 FIFO.
- Independent write and read enables, so a push and a pop can be accepted in the same cycle.
- Occupancy count and programmable almost-full / almost-empty thresholds.
- Sticky overflow and underflow error flags, clearable without a full reset.
- Selectable output mode: standard (registered read) or first-word-fall-through (FWFT).
- Intended for single-clock buffering between pipeline stages, with a testbench-friendly status interface.

Parameters:
DATA_W, 8, data word width in bits (≥1)
DEPTH, 16, number of entries; power of two, ≥4
AF_THRESH, 14, almost_full asserted when count ≥ AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on posedge clk
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data holds a valid word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count ≥ AF_THRESH
almost_empty  output  1  count ≤ AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH × DATA_W array.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit; the low bits index the array. Pointers wrap naturally from DEPTH-1 to 0 with the wrap bit toggling.
  - full = (ptr MSBs differ) && (low bits equal); empty = (ptrs equal).
  - count is a registered value. It must always equal wr_ptr − rd_ptr modulo 2·DEPTH.
- Reset (rst=1 at posedge) clears:
  - wr_ptr, rd_ptr and count to 0;
  - rd_data to 0 and rd_valid to 0;
  - overflow and underflow to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full = (AF_THRESH==0 ? 1 : 0).
  - Array contents are not cleared.
  - Reset takes priority over every other input. An operation in flight is discarded and nothing is retained.
- Accept rules, evaluated on state before the edge:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous accepted read frees a slot, so both are accepted.
  - When empty, a simultaneous read is rejected and the write is accepted. The written word is not bypassed to the output.
- Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Flags follow count in the same cycle as the updated count.
- Errors:
  - overflow is set on wr_en && !wr_acc.
  - underflow is set on rd_en && !rd_acc.
  - Both hold until rst or clr_err. If clr_err and a new error event occur in the same cycle, the set wins.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1, so data appears 1 cycle after the accepted read.
  - Without rd_acc, rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_valid = !empty; rd_data = mem[rd_ptr] combinationally; latency write→visible is 1 cycle.
  - rd_en while rd_valid pops the head; the next word is visible in the following cycle.
  - When empty, rd_data is don't-care and the bench must only check it while rd_valid=1.
- Write timing: mem[wr_ptr] <= wr_data on wr_acc.
- Ordering: strict FIFO order under all accept patterns, including wrap-around past entry DEPTH-1.

Test Plan:
- Reset, then fill: 16 writes 0x00..0x0F (DATA_W=8, DEPTH=16) -> count 16, full=1; almost_full rises when count reaches 14; a 17th write sets overflow and count stays 16.
- Drain in standard mode: 16 reads -> rd_data 0x00..0x0F each 1 cycle after rd_en, rd_valid pulses; empty=1 after the last read; an extra read sets underflow and rd_valid stays 0.
- Simultaneous when full: full FIFO, wr_en=rd_en=1 with wr_data 0xA5 -> head popped, write accepted, count stays 16, no overflow; 0xA5 emerges last.
- Simultaneous when empty: wr_en=rd_en=1 with 0x3C -> count 1, underflow=1, rd_valid=0; the next read returns 0x3C; clr_err clears underflow.
- Wrap-around: 40 interleaved write/read cycles with count kept between 3 and 10 -> output sequence equals input sequence; almost_empty=1 exactly when count ≤ 2.
- FWFT=1 and mid-operation reset: write 0x11 -> rd_valid=1, rd_data=0x11 next cycle with no rd_en; with 5 entries, assert rst -> count 0, empty=1, rd_valid=0, flags cleared.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a choice of registered or fall-through read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] AF_LIM = PW'(AF_THRESH);
  localparam logic [AW:0] AE_LIM = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              wr_acc;
  logic              rd_acc;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // The extra pointer bit distinguishes a full FIFO from an empty one.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr == rd_ptr);

  assign almost_full  = (count >= AF_LIM);
  assign almost_empty = (count <= AE_LIM);

  // A pop frees a slot in the same cycle, so a write into a full FIFO
  // is accepted when it is paired with an accepted read.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new error event in the same cycle as clr_err keeps the flag set.
      if (wr_en && !wr_acc)  overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;

      if (rd_en && !rd_acc)  underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) data_q <= mem[rd_idx];
        end
      end

      assign rd_data  = data_q;
      assign rd_valid = valid_q;
    end else begin : g_fwft
      // Head of queue is presented directly; only meaningful while rd_valid.
      assign rd_data  = mem[rd_idx];
      assign rd_valid = !empty;
    end
  endgenerate

endmodule
